adc_result_fifo: RTL and testbench

Result buffer placed directly downstream of the SAR ADC wrapper. Captures each completed 12-bit conversion on the rising edge of the controller's end-of-conversion/ack signal and stores it in a circular FIFO, so the host can drain several samples per SPI transaction instead of polling one result at a time. Runs on the system clock. Safely synchronises the ack, which originates in the slower divided ADC clock domain.

---
 rtl/adc_result_fifo.sv | 86 ++++++++
 tb/tb_adc_result_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_result_fifo.sv
// adc_result_fifo: captures ADC conversion results on the synchronised ack rising edge into a circular FIFO.
// Optional build macro ADC_FIFO_OVERWRITE_EN: a push into a full FIFO overwrites the oldest sample instead of being dropped.
module adc_result_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  sys_clk,
    input  logic                  reset_,
    input  logic                  enable,
    input  logic                  adc_ack,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  ovf_clr,
    input  logic [AW:0]           watermark,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  wm_irq
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic                  s1, s2, s3;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push_req, pop, wr_go, rd_go, ovf_set;
    logic [AW:0]           count_nxt;

    assign empty    = count == '0;
    assign full     = count == FULL_CNT;
    assign push_req = s2 & ~s3 & enable;
    assign pop      = rd_en & ~empty;
    assign ovf_set  = push_req & full & ~pop;
`ifdef ADC_FIFO_OVERWRITE_EN
    assign wr_go    = push_req;
    assign rd_go    = pop | (push_req & full);
`else
    assign wr_go    = push_req & (~full | pop);
    assign rd_go    = pop;
`endif

    // next fill level; a full-FIFO overwrite advances both pointers and leaves it unchanged
    always_comb
        count_nxt = flush ? '0 :
                    (wr_go & ~rd_go) ? count + 1'b1 :
                    (rd_go & ~wr_go) ? count - 1'b1 : count;

    // ack synchroniser and edge-history chain; runs regardless of enable and flush
    always_ff @(posedge sys_clk or negedge reset_)
        if (!reset_) {s1, s2, s3} <= '0;
        else         {s1, s2, s3} <= {adc_ack, s1, s2};

    // sample storage; contents are meaningless until pointed at, so no reset
    always_ff @(posedge sys_clk)
        if (wr_go & ~flush) mem[wr_ptr] <= adc_data;

    // pointers, fill level, flags and the registered read port
    always_ff @(posedge sys_clk or negedge reset_)
        if (!reset_) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            wm_irq   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            count    <= count_nxt;
            wm_irq   <= (watermark != '0) && (count_nxt >= watermark);
            rd_valid <= pop & ~flush;
            if (pop & ~flush) rd_data <= mem[rd_ptr];
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_go) wr_ptr <= wr_ptr + 1'b1;
                if (rd_go) rd_ptr <= rd_ptr + 1'b1;
                overflow <= ovf_set | (overflow & ~ovf_clr);
            end
        end
endmodule

// File: tb/tb_adc_result_fifo.sv
// tb_adc_result_fifo: directed and random checks of adc_result_fifo against a queue-based reference model.
module tb_adc_result_fifo;
    localparam int DEPTH = 16;

    logic        sys_clk = 1'b0, reset_ = 1'b0, enable = 1'b0, adc_ack = 1'b0;
    logic [11:0] adc_data = '0;
    logic        rd_en = 1'b0, flush = 1'b0, ovf_clr = 1'b0;
    logic [4:0]  watermark = '0;
    logic [11:0] rd_data;
    logic        rd_valid, empty, full, overflow, wm_irq;
    logic [4:0]  count;

    int errors = 0, checks = 0;
    logic [11:0] q[$];
    logic [11:0] last_rd = '0;
    bit          m_ovf = 0;

    adc_result_fifo dut (
        .sys_clk(sys_clk), .reset_(reset_), .enable(enable), .adc_ack(adc_ack),
        .adc_data(adc_data), .rd_en(rd_en), .flush(flush), .ovf_clr(ovf_clr),
        .watermark(watermark), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .wm_irq(wm_irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".wm_irq"}, 32'(wm_irq), 32'(watermark != 0 && q.size() >= int'(watermark)));
    endtask

    // one full ack pulse (2 high, 2 low); optional rd_en in the cycle the sample lands
    task automatic pulse(input logic [11:0] d, input bit with_pop, input string tag);
        bit had;
        logic [11:0] exp_rd;
        adc_data = d;
        adc_ack  = 1'b1;
        step();
        step();
        adc_ack = 1'b0;
        rd_en   = with_pop;
        step();
        rd_en = 1'b0;
        had = with_pop && q.size() != 0;
        exp_rd = had ? q[0] : last_rd;
        if (q.size() == DEPTH && !had) begin
            m_ovf = 1;
`ifdef ADC_FIFO_OVERWRITE_EN
            void'(q.pop_front());
            q.push_back(d);
`endif
        end else begin
            if (had) void'(q.pop_front());
            q.push_back(d);
        end
        last_rd = exp_rd;
        if (with_pop) begin
            chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(had));
            chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
        end
        step();
        chk({tag, ".strobe_end"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic pop(input string tag);
        bit had;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        had = q.size() != 0;
        if (had) last_rd = q.pop_front();
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(had));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(last_rd));
        step();
        chk({tag, ".strobe_end"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"}, 32'(full), 32'd0);
        chk({tag, ".overflow"}, 32'(overflow), 32'd0);
        chk({tag, ".wm_irq"}, 32'(wm_irq), 32'd0);
    endtask

    initial begin
        // reset
        repeat (3) step();
        chk_reset_outputs("reset");
        reset_ = 1'b1;
        enable = 1'b1;
        step();

        // basic capture
        pulse(12'h123, 0, "basic_push0");
        pulse(12'h456, 0, "basic_push1");
        pulse(12'h789, 0, "basic_push2");
        chk_state("basic_filled");
        chk("basic.count3", 32'(count), 32'd3);
        pop("basic_pop0");
        chk("basic.val0", 32'(rd_data), 32'h123);
        pop("basic_pop1");
        pop("basic_pop2");
        chk("basic.val2", 32'(rd_data), 32'h789);
        chk_state("basic_drained");
        pop("pop_empty");

        // overflow
        for (int i = 0; i <= 16; i++) pulse(12'(i), 0, "ovf_push");
        chk_state("ovf_full");
        chk("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop("ovf_drain");
        chk_state("ovf_drained");
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        m_ovf = 0;
        chk_state("ovf_clr");

        // simultaneous push and pop at full, then at empty
        for (int i = 0; i < DEPTH; i++) pulse(12'($urandom), 0, "sim_fill");
        chk_state("sim_full");
        pulse(12'($urandom), 1, "sim_full_pp");
        chk_state("sim_after_pp");
        while (q.size() != 0) pop("sim_drain");
        pulse(12'($urandom), 1, "sim_empty_pp");
        chk_state("sim_empty_after");
        pop("sim_empty_drain");

        // watermark
        watermark = 5'd4;
        for (int i = 0; i < 4; i++) begin
            pulse(12'($urandom), 0, "wm_push");
            chk_state("wm_fill");
        end
        pop("wm_pop");
        chk_state("wm_below");
        watermark = 5'd0;
        step();
        for (int i = 0; i < 6; i++) pulse(12'($urandom), 0, "wm0_push");
        chk_state("wm0");

        // flush at count 5 with overflow pending
        while (q.size() < DEPTH) pulse(12'($urandom), 0, "fl_fill");
        pulse(12'($urandom), 0, "fl_ovf");
        for (int i = 0; i < DEPTH - 5; i++) pop("fl_pop");
        chk_state("fl_pre");
        flush = 1'b1;
        step();
        flush = 1'b0;
        q.delete();
        m_ovf = 0;
        chk_state("flush");
        chk("flush.rd_valid", 32'(rd_valid), 32'd0);

        // enable raised while ack already high
        enable  = 1'b0;
        adc_ack = 1'b1;
        repeat (3) step();
        enable = 1'b1;
        repeat (3) step();
        adc_ack = 1'b0;
        repeat (3) step();
        chk_state("late_enable");

        // random traffic
        watermark = 5'($urandom_range(0, 16));
        step();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: pulse(12'($urandom), 0, "rnd_push");
                1: pulse(12'($urandom), 1, "rnd_pp");
                default: pop("rnd_pop");
            endcase
            chk_state("rnd");
        end

        // asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) pulse(12'($urandom), 0, "rst_fill");
        #2 reset_ = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        repeat (2) step();
        reset_ = 1'b1;
        q.delete();
        m_ovf = 0;
        last_rd = '0;
        step();
        chk_state("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
